// File: rtl/binary_tree_reduce_64_8_seq.sv
// binary_tree_reduce_64_8_seq
// Pipelined fan-in reduction tree. The 64 leaf operands are split into
// NUM_OUTPUT_DATA groups of NUM_FANOUT leaves. Each group sums the leaves
// selected by its slice of i_cmd through its own LEVELS-deep binary adder
// tree, one adder level per register stage. Validity and error flags are
// resolved at the input edge and then travel alongside the partial sums,
// so the last stage only has to zero the result of a group that is not valid.
// Every register shares the same enable (i_en) and the same synchronous
// active-low reset, and reset takes priority over the enable.

module binary_tree_reduce_64_8_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_OUTPUT_DATA = 8,
  parameter int NUM_FANOUT      = 8,
  localparam int NUM_INPUT_DATA = NUM_OUTPUT_DATA * NUM_FANOUT,
  localparam int LEVELS         = $clog2(NUM_FANOUT),
  localparam int OUT_WIDTH      = DATA_WIDTH + LEVELS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_en,
  input  logic [NUM_INPUT_DATA-1:0]            i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_INPUT_DATA-1:0]            i_cmd,
  output logic [NUM_OUTPUT_DATA-1:0]           o_valid,
  output logic [NUM_OUTPUT_DATA-1:0]           o_err,
  output logic [NUM_OUTPUT_DATA*OUT_WIDTH-1:0] o_data_bus,
  output logic [NUM_INPUT_DATA-1:0]            o_cmd
);

  // Bit offset of adder level n inside one group's packed tree register.
  // Level i holds NUM_FANOUT>>i nodes, each DATA_WIDTH+i bits wide, and
  // levels are packed back to back starting with level 1 at offset 0.
  function automatic int lvl_off(input int n);
    int off;
    off = 0;
    for (int i = 1; i < n; i++) begin
      off += (NUM_FANOUT >> i) * (DATA_WIDTH + i);
    end
    return off;
  endfunction

  localparam int TREE_BITS = lvl_off(LEVELS + 1);
  localparam int FINAL_OFF = lvl_off(LEVELS);

  // ---------------------------------------------------------------------
  // Per-group flag decode at the input edge
  // ---------------------------------------------------------------------
  logic [NUM_OUTPUT_DATA-1:0] any_s;
  logic [NUM_OUTPUT_DATA-1:0] bad_s;

  // A group is bad when its mask picks an invalid leaf; it is "any" when
  // the mask picks at least one leaf.
  always_comb begin
    any_s = '0;
    bad_s = '0;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      any_s[j] = |i_cmd[j*NUM_FANOUT +: NUM_FANOUT];
      bad_s[j] = |(i_cmd[j*NUM_FANOUT +: NUM_FANOUT] &
                   ~i_valid[j*NUM_FANOUT +: NUM_FANOUT]);
    end
  end

  // ---------------------------------------------------------------------
  // Flag and command pipeline (one entry per adder level)
  // ---------------------------------------------------------------------
  logic [NUM_OUTPUT_DATA-1:0] vld_r [LEVELS];
  logic [NUM_OUTPUT_DATA-1:0] err_r [LEVELS];
  logic [NUM_INPUT_DATA-1:0]  cmd_r [LEVELS];

  // Carry valid/err flags and the command word in lockstep with the sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < LEVELS; n++) begin
        vld_r[n] <= '0;
        err_r[n] <= '0;
        cmd_r[n] <= '0;
      end
    end else if (i_en) begin
      vld_r[0] <= any_s & ~bad_s;
      err_r[0] <= bad_s;
      cmd_r[0] <= i_cmd;
      for (int n = 1; n < LEVELS; n++) begin
        vld_r[n] <= vld_r[n-1];
        err_r[n] <= err_r[n-1];
        cmd_r[n] <= cmd_r[n-1];
      end
    end
  end

  // Validity of the vector entering the last adder level; it decides
  // whether the final sum is kept or forced to zero.
  logic [NUM_OUTPUT_DATA-1:0] last_vld_s;

  if (LEVELS == 1) begin : gen_last_in
    assign last_vld_s = any_s & ~bad_s;
  end else begin : gen_last_pipe
    assign last_vld_s = vld_r[LEVELS-2];
  end

  // ---------------------------------------------------------------------
  // Adder trees: all groups packed side by side, TREE_BITS each
  // ---------------------------------------------------------------------
  wire  [NUM_OUTPUT_DATA*TREE_BITS-1:0] tree_s;
  logic [NUM_OUTPUT_DATA*TREE_BITS-1:0] tree_r;

  for (genvar g = 0; g < NUM_OUTPUT_DATA; g++) begin : gen_grp
    for (genvar n = 1; n <= LEVELS; n++) begin : gen_lvl
      localparam int W    = DATA_WIDTH + n;
      localparam int BASE = g * TREE_BITS + lvl_off(n);
      for (genvar m = 0; m < (NUM_FANOUT >> n); m++) begin : gen_node
        logic [W-1:0] sum_s;
        if (n == 1) begin : gen_leaf
          // Unselected leaves are replaced by zero so their data, even if
          // unknown, never reaches the adders.
          localparam int LA = g * NUM_FANOUT + 2 * m;
          logic [DATA_WIDTH-1:0] a_s;
          logic [DATA_WIDTH-1:0] b_s;
          assign a_s   = i_cmd[LA]     ? i_data_bus[LA*DATA_WIDTH +: DATA_WIDTH]     : '0;
          assign b_s   = i_cmd[LA + 1] ? i_data_bus[(LA+1)*DATA_WIDTH +: DATA_WIDTH] : '0;
          assign sum_s = {1'b0, a_s} + {1'b0, b_s};
        end else begin : gen_inner
          localparam int PO = g * TREE_BITS + lvl_off(n - 1) + 2 * m * (W - 1);
          assign sum_s = {1'b0, tree_r[PO +: W-1]} + {1'b0, tree_r[PO + W - 1 +: W-1]};
        end
        if (n == LEVELS) begin : gen_final
          assign tree_s[BASE + m*W +: W] = last_vld_s[g] ? sum_s : '0;
        end else begin : gen_mid
          assign tree_s[BASE + m*W +: W] = sum_s;
        end
      end
    end
  end

  // Register every adder level of every group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tree_r <= '0;
    end else if (i_en) begin
      tree_r <= tree_s;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: straight from the last register stage
  // ---------------------------------------------------------------------
  assign o_valid = vld_r[LEVELS-1];
  assign o_err   = err_r[LEVELS-1];
  assign o_cmd   = cmd_r[LEVELS-1];

  // Gather each group's root node into the output bus.
  always_comb begin
    o_data_bus = '0;
    for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
      o_data_bus[j*OUT_WIDTH +: OUT_WIDTH] = tree_r[j*TREE_BITS + FINAL_OFF +: OUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_binary_tree_reduce_64_8_seq.sv
// Testbench for binary_tree_reduce_64_8_seq. A reference model computes each
// accepted vector's result with plain loops and keeps a history indexed by
// the number of enabled, non-reset edges since the last reset; the result of
// the vector accepted three such edges ago is what the outputs must show.
// Directed scenarios add literal expectations on top of the model check.

module tb_binary_tree_reduce_64_8_seq;

  localparam int DW = 32;
  localparam int NO = 8;
  localparam int NF = 8;
  localparam int NI = NO * NF;
  localparam int OW = DW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               i_en;
  logic [NI-1:0]      i_valid;
  logic [NI*DW-1:0]   i_data_bus;
  logic [NI-1:0]      i_cmd;
  logic [NO-1:0]      o_valid;
  logic [NO-1:0]      o_err;
  logic [NO*OW-1:0]   o_data_bus;
  logic [NI-1:0]      o_cmd;

  binary_tree_reduce_64_8_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [NO-1:0]    vld;
    logic [NO-1:0]    err;
    logic [NO*OW-1:0] data;
    logic [NI-1:0]    cmd;
  } res_t;

  // Result of one input vector, straight from the functional rules.
  function automatic res_t model(input logic [NI-1:0] v, input logic [NI*DW-1:0] d,
                                 input logic [NI-1:0] c);
    res_t r;
    r = '0;
    r.cmd = c;
    for (int j = 0; j < NO; j++) begin
      logic [63:0] sum;
      logic bad, any;
      sum = 64'd0;
      bad = 1'b0;
      any = 1'b0;
      for (int k = 0; k < NF; k++) begin
        int l;
        l = j * NF + k;
        if (c[l]) begin
          any = 1'b1;
          if (!v[l]) bad = 1'b1;
          sum = sum + {32'd0, d[l*DW +: DW]};
        end
      end
      r.vld[j] = any && !bad;
      r.err[j] = bad;
      r.data[j*OW +: OW] = r.vld[j] ? sum[OW-1:0] : {OW{1'b0}};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model history: one entry per accepted vector since the last reset.
  res_t hist [0:1023];
  int   cnt   = 0;
  bit   armed = 1'b0;
  res_t exp_r;

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 0;
      armed <= 1'b1;
    end else if (i_en) begin
      hist[cnt] <= model(i_valid, i_data_bus, i_cmd);
      cnt       <= cnt + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (armed) begin
      exp_r = (cnt >= 3) ? hist[cnt-3] : '0;
      chk("cyc_valid", o_valid,    exp_r.vld);
      chk("cyc_err",   o_err,      exp_r.err);
      chk("cyc_data",  o_data_bus, exp_r.data);
      chk("cyc_cmd",   o_cmd,      exp_r.cmd);
    end
  end

  task automatic drive(input logic rst, input logic en, input logic [NI-1:0] v,
                       input logic [NI*DW-1:0] d, input logic [NI-1:0] c);
    rst_n      = rst;
    i_en       = en;
    i_valid    = v;
    i_data_bus = d;
    i_cmd      = c;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, {NI{1'b1}}, {NI*DW{1'b0}}, {NI{1'b0}});
  endtask

  // Vector with only leaf 0 selected, carrying value s.
  task automatic send0(input logic en, input logic rst, input logic [31:0] s);
    logic [NI*DW-1:0] d;
    d = '0;
    d[DW-1:0] = s;
    drive(rst, en, {NI{1'b1}}, d, 64'h0000_0000_0000_0001);
  endtask

  initial begin
    logic [NI*DW-1:0] d;
    logic [NI-1:0]    c;
    logic [NI-1:0]    v;
    res_t             pin;

    rst_n = 1'b0; i_en = 1'b1; i_valid = '0; i_cmd = '0; i_data_bus = '0;
    drive(1'b0, 1'b1, '0, '0, '0);
    drive(1'b0, 1'b1, '0, '0, '0);
    chk("rst_valid", o_valid,    8'h00);
    chk("rst_err",   o_err,      8'h00);
    chk("rst_data",  o_data_bus, 280'd0);
    chk("rst_cmd",   o_cmd,      64'd0);

    // Multicast sum: leaves 60 and 63 of group 7 (61 + 64)
    for (int l = 0; l < NI; l++) d[l*DW +: DW] = 32'(l + 1);
    c = '0;
    c[63:56] = 8'b1001_0000;
    pin = model({NI{1'b1}}, d, c);
    chk("model_pin_mc", pin.data[7*OW +: OW], 35'h7D);
    drive(1'b1, 1'b1, {NI{1'b1}}, d, c);
    idle(); idle();
    chk("mc_valid",  o_valid,                  8'h80);
    chk("mc_err",    o_err,                    8'h00);
    chk("mc_slice7", o_data_bus[7*OW +: OW],   35'h7D);
    chk("mc_others", o_data_bus[7*OW-1:0],     245'd0);
    chk("mc_cmd",    o_cmd,                    64'h9000_0000_0000_0000);

    // Max width: eight all-ones leaves in group 0, everything else unknown
    d = 'x;
    for (int k = 0; k < 8; k++) d[k*DW +: DW] = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, {NI{1'b1}}, d, 64'h0000_0000_0000_00FF);
    idle(); idle();
    chk("max_slice0", o_data_bus[0 +: OW], 35'h7_FFFF_FFF8);
    chk("max_valid",  o_valid,             8'h01);

    // Invalid leaf 63 selected by group 7; group 6 takes leaf 48
    for (int l = 0; l < NI; l++) d[l*DW +: DW] = 32'(l + 1);
    d[48*DW +: DW] = 32'h30;
    v = '1; v[63] = 1'b0;
    c = '0; c[63] = 1'b1; c[48] = 1'b1;
    pin = model(v, d, c);
    chk("model_pin_err", {pin.vld, pin.err}, 16'h4080);
    drive(1'b1, 1'b1, v, d, c);
    idle(); idle();
    chk("inv_valid",  o_valid,                8'h40);
    chk("inv_err",    o_err,                  8'h80);
    chk("inv_slice7", o_data_bus[7*OW +: OW], 35'h0);
    chk("inv_slice6", o_data_bus[6*OW +: OW], 35'h30);

    // Streaming: 5, 6, 7 back to back
    send0(1'b1, 1'b1, 32'd5);
    send0(1'b1, 1'b1, 32'd6);
    send0(1'b1, 1'b1, 32'd7);
    chk("str_5", o_data_bus[0 +: OW], 35'd5);
    idle();
    chk("str_6", o_data_bus[0 +: OW], 35'd6);
    idle();
    chk("str_7", o_data_bus[0 +: OW], 35'd7);
    idle();
    chk("str_end_valid", o_valid, 8'h00);

    // Stall for two edges with 4 at the output and 5, 6 in flight
    send0(1'b1, 1'b1, 32'd4);
    send0(1'b1, 1'b1, 32'd5);
    send0(1'b1, 1'b1, 32'd6);
    chk("stl_pre", o_data_bus[0 +: OW], 35'd4);
    for (int l = 0; l < NI; l++) d[l*DW +: DW] = 32'(l + 100);
    drive(1'b1, 1'b0, {NI{1'b1}}, d, {NI{1'b1}});
    chk("stl_hold1", o_data_bus[0 +: OW], 35'd4);
    drive(1'b1, 1'b0, {NI{1'b1}}, d, {NI{1'b1}});
    chk("stl_hold2",  o_data_bus[0 +: OW], 35'd4);
    chk("stl_hold_v", o_valid,             8'h01);
    idle();
    chk("stl_5", o_data_bus[0 +: OW], 35'd5);
    idle();
    chk("stl_6", o_data_bus[0 +: OW], 35'd6);
    idle();
    chk("stl_end_valid", o_valid, 8'h00);

    // Mid-flight reset with 8 and 9 in flight
    send0(1'b1, 1'b1, 32'd8);
    send0(1'b1, 1'b1, 32'd9);
    send0(1'b1, 1'b0, 32'd11);
    chk("mrst_valid", o_valid,    8'h00);
    chk("mrst_err",   o_err,      8'h00);
    chk("mrst_data",  o_data_bus, 280'd0);
    chk("mrst_cmd",   o_cmd,      64'd0);
    send0(1'b1, 1'b1, 32'd10);
    chk("mrst_gap1", o_valid, 8'h00);
    idle();
    chk("mrst_gap2", o_valid, 8'h00);
    idle();
    chk("mrst_10",   o_data_bus[0 +: OW], 35'd10);
    chk("mrst_10_v", o_valid,             8'h01);
    idle(); idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/binary_tree_reduce_64_8_seq.md
# binary_tree_reduce_64_8_seq

Pipelined binary reduction (fan-in) tree, the collection-side counterpart of the 8-to-64 multicast distribution tree. It accepts 64 leaf operands organised as 8 groups of 8. Per output it sums the leaves selected by that group's 8-bit command mask, producing 8 reduced results plus the command that produced them. It sits between the PE array outputs and the 8 global-buffer write ports, and carries valid/enable semantics consistent with the distribution side.

## Interface

Parameters:
- DATA_WIDTH, 32, leaf operand width (unsigned).
- NUM_OUTPUT_DATA, 8, number of reduced outputs (groups).
- NUM_FANOUT, 8, leaves per group; power of 2, ≥2.
- Derived: NUM_INPUT_DATA = NUM_OUTPUT_DATA*NUM_FANOUT (64); LEVELS = log2(NUM_FANOUT) (3); OUT_WIDTH = DATA_WIDTH+LEVELS (35).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_en  in  1  global pipeline enable; 0 freezes every pipeline register.
- i_valid  in  NUM_INPUT_DATA  per-leaf valid; leaf l = j*NUM_FANOUT+k.
- i_data_bus  in  NUM_INPUT_DATA*DATA_WIDTH  leaf l at [l*DATA_WIDTH +: DATA_WIDTH].
- i_cmd  in  NUM_INPUT_DATA  select mask; bit l = include leaf l in output j's sum.
- o_valid  out  NUM_OUTPUT_DATA  output j holds a good sum.
- o_err  out  NUM_OUTPUT_DATA  output j's mask selected at least one invalid leaf.
- o_data_bus  out  NUM_OUTPUT_DATA*OUT_WIDTH  output j at [j*OUT_WIDTH +: OUT_WIDTH].
- o_cmd  out  NUM_INPUT_DATA  i_cmd delayed to align with o_data_bus.

## Operation

- Each group j has its own LEVELS-deep binary adder tree. Level n adders are n+DATA_WIDTH bits wide, operands zero-extended, and there is no overflow by construction.
- Leaf contribution = i_cmd[l] ? i_data_bus leaf : 0. Unselected leaf data is never used, even if X/Z.
- Per group j, at the input edge:
  - sel_j = i_cmd group j slice.
  - bad_j = |(sel_j & ~i_valid slice).
  - any_j = |sel_j.
- Result flags, carried through the pipeline:
  - o_valid[j] = any_j & ~bad_j.
  - o_err[j] = bad_j.
  - If o_valid[j]=0, o_data_bus slice j is forced to 0, including the err case.
- Mask 0 for a group gives o_valid=0, o_err=0, data 0. This is not an error.
- o_cmd travels through the same register stages as the data, unmodified.
- There are no internal state machines beyond the pipeline. Every stage register has the same enable (i_en) and the same reset.

## Timing

- Pipeline depth = LEVELS register stages (3); the level-n adder output is registered at stage n.
- Latency: inputs sampled at rising edge k with i_en=1 appear on outputs after edge k+LEVELS-1 (3 enabled edges total: k, k+1, k+2). They are stable from just after edge k+2 until the next enabled edge.
- Throughput: one vector per enabled cycle. There is no backpressure and no bubbles are inserted.
- i_en=0 at an edge: all stage registers, flags and o_cmd hold their values; inputs are ignored and not captured. Resuming continues in order with no loss or duplication.
- rst_n=0 at an edge: every stage register is cleared regardless of i_en (reset wins), and all in-flight vectors are discarded.
- Reset values: o_valid=0, o_err=0, o_data_bus=0, o_cmd=0.
- Reset released: the first vector sampled at edge k appears after edge k+2. Intermediate stages output zeros/invalid until then, never stale data.
- o_valid/o_err of different groups are independent. One group erring never affects another group.

## Test plan

- Multicast sum: leaf l data = l+1, all valid, group 7 mask 8'b10010000, others 0 → after 3 edges o_valid=8'h80, o_err=0, slice 7 = 0x7D (61+64), all other slices 0, o_cmd = i_cmd.
- Max-width: group 0 mask 8'hFF, leaves 0..7 = 0xFFFFFFFF → slice 0 = 35'h7_FFFF_FFF8, o_valid[0]=1.
- Invalid leaf: i_valid[63]=0, group 7 mask 8'h80, group 6 mask 8'h01 (leaf 48 data 0x30) → o_valid=8'h40, o_err=8'h80, slice 7=0, slice 6=0x30.
- Streaming: three back-to-back vectors with group 0 sums 5, 6, 7 → slice 0 reads 5, 6, 7 on three consecutive cycles starting 3 edges after the first.
- Stall: drop i_en for 2 edges while 2 vectors are in flight → outputs hold unchanged for 2 cycles, then the remaining vectors emerge in order with no duplicates.
- Mid-flight reset: rst_n=0 for one edge with 2 vectors in flight and i_en=1 → next cycle all outputs 0. Neither vector ever appears, and the next vector after release emerges after 3 edges.
